// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - fixed-latency byte-addressed data memory with request/ready handshake
// Serves 4-byte word accesses; busy stalls the requester while an access is in flight.
module data_memory_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we_memory,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        ready,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LOAD   = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:2] word_q, word_d;
    logic                  we_q, we_d;
    logic [7:0]            wdata_q [0:3];
    logic [7:0]            wdata_d [0:3];
    logic [7:0]            rdata_q [0:3];
    logic                  busy_q, ready_q;
    logic                  rd_load;
    logic [7:0]            mem [0:DEPTH-1];

    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    word_d  = mem_addr[ADDR_WIDTH-1:2];
                    we_d    = we_memory;
                    wdata_d = mem_data_in;
                    cnt_d   = LOAD;
                    state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Read data is captured on the edge entering DONE so it is valid alongside ready.
        rd_load = (state_d == S_DONE) && (state_q != S_DONE) && !we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rdata_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_DONE);
            if (rd_load) begin
                for (int i = 0; i < 4; i++) begin
                    rdata_q[i] <= mem[{word_d, 2'(i)}];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        word_q  <= word_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    // Writes commit only on the edge leaving DONE, so a reset before then drops them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_DONE && we_q) begin
            for (int i = 0; i < 4; i++) begin
                mem[{word_q, 2'(i)}] <= wdata_q[i];
            end
        end
    end

    assign mem_data_out = rdata_q;
    assign busy         = busy_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_data_memory_port.sv
// tb/tb_data_memory_port.sv - self-checking bench for data_memory_port
// Two instances: LATENCY=4 and LATENCY=1, both with ADDR_WIDTH=16.
module tb_data_memory_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1;
    logic [7:0]  din0 [0:3];
    logic [7:0]  din1 [0:3];
    logic [7:0]  dout0 [0:3];
    logic [7:0]  dout1 [0:3];
    logic        rdy0, rdy1, busy0, busy1;

    data_memory_port #(.ADDR_WIDTH(16), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req(req0), .we_memory(we0), .mem_addr(addr0),
        .mem_data_in(din0), .mem_data_out(dout0), .ready(rdy0), .busy(busy0)
    );

    data_memory_port #(.ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req1), .we_memory(we1), .mem_addr(addr1),
        .mem_data_in(din1), .mem_data_out(dout1), .ready(rdy1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;
    int rdy_cnt0 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] b [0:3]);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Transaction-level model: one access per accept, ready L cycles later.
    int          lat [2] = '{4, 1};
    bit          act [2];
    int          mk [2];
    bit          mwe [2];
    logic [15:0] mbase [2];
    logic [31:0] mdat [2];
    logic [31:0] eout [2];
    bit          ebusy [2];
    bit          erdy [2];
    logic [7:0]  mm [2][65536];
    int          cyc = 0;
    logic        m_rq, m_w;
    logic [31:0] m_a, m_dv;

    initial begin
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; eout[d] = 0; ebusy[d] = 0; erdy[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                m_rq = (d == 0) ? req0 : req1;
                m_w  = (d == 0) ? we0 : we1;
                m_a  = (d == 0) ? addr0 : addr1;
                m_dv = (d == 0) ? pack(din0) : pack(din1);
                if (rst) begin
                    act[d]  = 0;
                    eout[d] = 32'h0;
                end else if (act[d]) begin
                    if (cyc == mk[d] + lat[d]) begin
                        if (mwe[d]) begin
                            for (int i = 0; i < 4; i++)
                                mm[d][mbase[d] + 16'(i)] = mdat[d][31-8*i -: 8];
                        end
                        act[d] = 0;
                    end
                end else if (m_rq) begin
                    act[d]   = 1;
                    mk[d]    = cyc;
                    mwe[d]   = m_w;
                    mbase[d] = {m_a[15:2], 2'b00};
                    mdat[d]  = m_dv;
                end
                ebusy[d] = act[d];
                erdy[d]  = act[d] && (cyc + 1 == mk[d] + lat[d]);
                if (erdy[d] && !mwe[d])
                    eout[d] = {mm[d][mbase[d]], mm[d][mbase[d] + 16'd1],
                               mm[d][mbase[d] + 16'd2], mm[d][mbase[d] + 16'd3]};
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rdy0) rdy_cnt0++;
            if (cmp_on) begin
                chk("busy_l4",  {31'd0, busy0}, {31'd0, ebusy[0]});
                chk("ready_l4", {31'd0, rdy0},  {31'd0, erdy[0]});
                chk("dout_l4",  pack(dout0),    eout[0]);
                chk("busy_l1",  {31'd0, busy1}, {31'd0, ebusy[1]});
                chk("ready_l1", {31'd0, rdy1},  {31'd0, erdy[1]});
                chk("dout_l1",  pack(dout1),    eout[1]);
            end
        end
    end

    task automatic setd0(input logic [31:0] v);
        for (int i = 0; i < 4; i++) din0[i] = v[31-8*i -: 8];
    endtask

    task automatic setd1(input logic [31:0] v);
        for (int i = 0; i < 4; i++) din1[i] = v[31-8*i -: 8];
    endtask

    task automatic access0(input string nm, input logic w, input logic [31:0] a,
                           input logic [31:0] dat, input bit chk_rd, input logic [31:0] exp_rd);
        int  n;
        bit  found;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = w; addr0 = a; setd0(dat);
        @(posedge clk); #1;
        req0 = 1'b0;
        n = 1;
        found = 0;
        while (n <= 20 && !found) begin
            @(negedge clk);
            if (rdy0) found = 1;
            else n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        if (chk_rd) chk({nm, "_data"}, pack(dout0), exp_rd);
    endtask

    logic [31:0] wd [3] = '{32'h5AA53CC3, 32'h01234567, 32'hFEDCBA98};
    logic [31:0] prev;
    int          r0;

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; setd0(32'h0);
        req1 = 0; we1 = 0; addr1 = 0; setd1(32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        chk("reset_busy",  {31'd0, busy0}, 32'd0);
        chk("reset_ready", {31'd0, rdy0},  32'd0);
        chk("reset_dout",  pack(dout0),    32'h0);
        chk("reset_dout1", pack(dout1),    32'h0);

        access0("wr100", 1'b1, 32'h0000_0100, 32'hAABBCCDD, 0, 32'h0);
        access0("rd100", 1'b0, 32'h0000_0100, 32'h0, 1, 32'hAABBCCDD);

        access0("wr104", 1'b1, 32'h0000_0104, 32'h11223344, 0, 32'h0);
        access0("rd107", 1'b0, 32'h0000_0107, 32'h0, 1, 32'h11223344);
        access0("rdwrap", 1'b0, 32'h0001_0104, 32'h0, 1, 32'h11223344);

        // Requests arriving in WAIT and DONE must be ignored.
        access0("wr300", 1'b1, 32'h0000_0300, 32'hC1C2C3C4, 0, 32'h0);
        access0("wr200", 1'b1, 32'h0000_0200, 32'hB1B2B3B4, 0, 32'h0);
        @(posedge clk); #1;
        r0 = rdy_cnt0;
        req0 = 1; we0 = 0; addr0 = 32'h200; setd0(32'h0);
        @(posedge clk); #1 req0 = 0;
        @(posedge clk); #1 req0 = 1; we0 = 1; addr0 = 32'h300; setd0(32'hFFFFFFFF);
        @(posedge clk); #1 req0 = 0;
        @(posedge clk); #1 req0 = 1;
        @(negedge clk);
        chk("busyreq_ready", {31'd0, rdy0}, 32'd1);
        chk("busyreq_data",  pack(dout0),   32'hB1B2B3B4);
        @(posedge clk); #1 req0 = 0; we0 = 0;
        repeat (4) @(negedge clk);
        chk("busyreq_one_ready", 32'(rdy_cnt0 - r0), 32'd1);
        access0("rd300", 1'b0, 32'h0000_0300, 32'h0, 1, 32'hC1C2C3C4);

        // Reset in the middle of a write leaves storage untouched.
        access0("wr400", 1'b1, 32'h0000_0400, 32'hE1E2E3E4, 0, 32'h0);
        access0("rd400a", 1'b0, 32'h0000_0400, 32'h0, 1, 32'hE1E2E3E4);
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 32'h400; setd0(32'h01020304);
        @(posedge clk); #1 req0 = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rstmid_busy",  {31'd0, busy0}, 32'd0);
        chk("rstmid_ready", {31'd0, rdy0},  32'd0);
        chk("rstmid_dout",  pack(dout0),    32'h0);
        access0("rd400b", 1'b0, 32'h0000_0400, 32'h0, 1, 32'hE1E2E3E4);

        // LATENCY=1, req held high with alternating write/read.
        prev = 32'h0;
        @(posedge clk); #1;
        req1 = 1;
        for (int i = 0; i < 3; i++) begin
            we1 = 1; addr1 = 32'h10; setd1(wd[i]);
            @(negedge clk);
            chk("l1_idle_ready", {31'd0, rdy1}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("l1_wr_ready", {31'd0, rdy1}, 32'd1);
            chk("l1_hold_dout", pack(dout1), prev);
            @(posedge clk); #1;
            we1 = 0; addr1 = 32'h13;
            @(negedge clk);
            chk("l1_idle_ready2", {31'd0, rdy1}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("l1_rd_ready", {31'd0, rdy1}, 32'd1);
            chk("l1_rd_data", pack(dout1), wd[i]);
            prev = wd[i];
            @(posedge clk); #1;
        end
        req1 = 0;

        // Reset wins over a simultaneous request.
        @(posedge clk); #1;
        rst = 1; req0 = 1; we0 = 0; addr0 = 32'h100;
        @(posedge clk); #1;
        rst = 0; req0 = 0;
        @(negedge clk);
        chk("rstreq_busy",  {31'd0, busy0}, 32'd0);
        chk("rstreq_ready", {31'd0, rdy0},  32'd0);
        @(negedge clk);
        chk("rstreq_busy2", {31'd0, busy0}, 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
